// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin stage arbiter.
package arb_pkg;

  localparam int N_DEFAULT = 4;

  // Width of a requester index for n requesters.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant_logic.sv
// Rotating-priority grant: picks the first requester at or after prio, wrapping modulo N.
module rr_grant_logic
  import arb_pkg::*;
#(
  parameter  int N   = N_DEFAULT,
  localparam int IDW = idx_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] prio,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  // Scan positions prio, prio+1, ... and keep only the first hit.
  always_comb begin : scan_p
    logic           found_s;
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] pos_s;
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    pos_s     = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, prio} + (IDW + 1)'(k);
      // One subtraction suffices: prio < N and k < N.
      if (sum_s >= (IDW + 1)'(N)) begin
        sum_s = sum_s - (IDW + 1)'(N);
      end else begin
        sum_s = sum_s;
      end
      pos_s = sum_s[IDW-1:0];
      if (!found_s && req[pos_s]) begin
        grant[pos_s] = 1'b1;
        grant_idx    = pos_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/rr_stage_arbiter.sv
// N-to-1 round-robin arbiter feeding a single-entry output stage with full-throughput handshake.
module rr_stage_arbiter
  import arb_pkg::*;
#(
  parameter  int  N   = N_DEFAULT,
  parameter  type T   = logic [7:0],
  localparam int  IDW = idx_w(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush_in,
  input  logic [N-1:0]   valid_in,
  output logic [N-1:0]   ready_in,
  input  T               data_in [N],
  output logic           valid_out,
  input  logic           ready_out,
  output T               data_out,
  output logic [IDW-1:0] src_out,
  output logic [N-1:0]   grant_out
);

  logic           full_r;
  T               hold_data_r;
  logic [IDW-1:0] hold_src_r;
  logic [IDW-1:0] prio_r;

  logic [N-1:0]   grant_s;
  logic [IDW-1:0] grant_idx_s;
  logic           can_accept_s;
  logic           accept_s;
  logic [IDW-1:0] prio_next_s;

  rr_grant_logic #(.N(N)) u_grant (
    .req       (valid_in),
    .prio      (prio_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Handshake: the slot can take a beat when empty or being drained this cycle.
  always_comb begin
    can_accept_s = !flush_in && (!full_r || ready_out);
    accept_s     = can_accept_s && (|valid_in);
    grant_out    = grant_s;
    if (!reset && can_accept_s) begin
      ready_in = grant_s;
    end else begin
      ready_in = '0;
    end
    if (grant_idx_s == IDW'(N - 1)) begin
      prio_next_s = '0;
    end else begin
      prio_next_s = grant_idx_s + IDW'(1);
    end
  end

  // Hold register, full flag and priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r      <= 1'b0;
      hold_data_r <= '0;
      hold_src_r  <= '0;
      prio_r      <= '0;
    end else if (flush_in) begin
      full_r <= 1'b0;
    end else if (accept_s) begin
      // Covers simultaneous read: the new beat overwrites the departing one.
      full_r      <= 1'b1;
      hold_data_r <= data_in[grant_idx_s];
      hold_src_r  <= grant_idx_s;
      prio_r      <= prio_next_s;
    end else if (full_r && ready_out) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign valid_out = full_r;
  assign data_out  = hold_data_r;
  assign src_out   = hold_src_r;

endmodule

// File: tb/tb_rr_stage_arbiter.sv
// Self-checking bench: directed scenarios plus a per-cycle slot model for N=4 and N=3 instances.
module tb_rr_stage_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush4, ready4, flush3, ready3;
  logic [3:0] valid4, rin4, gnt4;
  logic [2:0] valid3, rin3, gnt3;
  logic [7:0] d4 [4];
  logic [7:0] d3 [3];
  logic       vo4, vo3;
  logic [7:0] do4, do3;
  logic [1:0] so4, so3;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: a one-slot buffer per instance (index 0 -> N=4, 1 -> N=3).
  bit         mfull [2];
  logic [7:0] mdata [2];
  int         msrc  [2];
  int         mprio [2];

  always #5 clk = ~clk;

  rr_stage_arbiter #(.N(4)) u4 (
    .clk(clk), .reset(reset), .flush_in(flush4), .valid_in(valid4), .ready_in(rin4),
    .data_in(d4), .valid_out(vo4), .ready_out(ready4), .data_out(do4), .src_out(so4),
    .grant_out(gnt4)
  );

  rr_stage_arbiter #(.N(3)) u3 (
    .clk(clk), .reset(reset), .flush_in(flush3), .valid_in(valid3), .ready_in(rin3),
    .data_in(d3), .valid_out(vo3), .ready_out(ready3), .data_out(do3), .src_out(so3),
    .grant_out(gnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] v, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [15:0] oh(input int g);
    logic [15:0] one;
    one = 16'd1;
    return (g < 0) ? 16'd0 : (one << g);
  endfunction

  task automatic model_step(input int i, input bit rst, input bit fl, input bit rdy,
                            input int g, input int n, input logic [7:0] dg);
    bit can, acc, rd;
    int occ;
    can = !fl && (!mfull[i] || rdy);
    acc = can && (g >= 0);
    rd  = mfull[i] && rdy;
    if (rst) begin
      mfull[i] = 1'b0; mdata[i] = 8'h00; msrc[i] = 0; mprio[i] = 0;
    end else if (fl) begin
      mfull[i] = 1'b0;
    end else begin
      occ = int'(mfull[i]) - int'(rd) + int'(acc);
      mfull[i] = (occ > 0);
      if (acc) begin
        mdata[i] = dg; msrc[i] = g; mprio[i] = (g + 1) % n;
      end
    end
  endtask

  int mg4, mg3;
  // Advance the model on each rising edge with the inputs the DUT saw.
  always @(posedge clk) begin
    mg4 = pick({12'd0, valid4}, mprio[0], 4);
    mg3 = pick({13'd0, valid3}, mprio[1], 3);
    model_step(0, reset, flush4, ready4, mg4, 4, (mg4 >= 0) ? d4[mg4[1:0]] : 8'h00);
    model_step(1, reset, flush3, ready3, mg3, 3, (mg3 >= 0) ? d3[mg3[1:0]] : 8'h00);
  end

  int cg4, cg3;
  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      cg4 = pick({12'd0, valid4}, mprio[0], 4);
      cg3 = pick({13'd0, valid3}, mprio[1], 3);
      chk("n4_grant", 32'(gnt4), 32'(oh(cg4)));
      chk("n4_ready", 32'(rin4), (!reset && !flush4 && (!mfull[0] || ready4)) ? 32'(oh(cg4)) : 32'd0);
      chk("n4_valid", 32'(vo4), 32'(mfull[0]));
      if (mfull[0]) begin
        chk("n4_data", 32'(do4), 32'(mdata[0]));
        chk("n4_src", 32'(so4), 32'(msrc[0]));
      end
      chk("n3_grant", 32'(gnt3), 32'(oh(cg3)));
      chk("n3_ready", 32'(rin3), (!reset && !flush3 && (!mfull[1] || ready3)) ? 32'(oh(cg3)) : 32'd0);
      chk("n3_valid", 32'(vo3), 32'(mfull[1]));
      if (mfull[1]) begin
        chk("n3_data", 32'(do3), 32'(mdata[1]));
        chk("n3_src", 32'(so3), 32'(msrc[1]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] tbl [10];
  logic [3:0] g36 [4];

  initial begin
    for (int i = 0; i < 2; i++) begin
      mfull[i] = 1'b0; mdata[i] = 8'h00; msrc[i] = 0; mprio[i] = 0;
    end
    reset = 1'b1; flush4 = 1'b0; ready4 = 1'b0; valid4 = 4'b1111;
    flush3 = 1'b0; ready3 = 1'b0; valid3 = 3'b000;
    for (int i = 0; i < 4; i++) d4[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);
    step();
    started = 1'b1;
    step();
    // Reset state
    chk("rst_valid_out", 32'(vo4), 32'd0);
    chk("rst_data_out", 32'(do4), 32'h00);
    chk("rst_src_out", 32'(so4), 32'd0);
    chk("rst_ready_in", 32'(rin4), 32'd0);

    // Full-throughput rotation over all four requesters
    reset = 1'b0; ready4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rot_valid", 32'(vo4), 32'd1);
      chk("rot_src", 32'(so4), 32'(i % 4));
      chk("rot_data", 32'(do4), 32'h10 + 32'(i % 4));
    end

    // Sparse requesters 0 and 2, with wrap from prio 3 back to 0
    g36[0] = 4'b0001; g36[1] = 4'b0100; g36[2] = 4'b0001; g36[3] = 4'b0100;
    valid4 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_grant", 32'(gnt4), 32'(g36[i]));
      if (i == 2) chk("alt_model_prio", 32'(mprio[0]), 32'd3);
      step();
      chk("alt_src", 32'(so4), (i % 2 == 0) ? 32'd0 : 32'd2);
    end

    // Fill from requester 1, then stall
    valid4 = 4'b0010; d4[1] = 8'h5A;
    #1;
    chk("fill_grant", 32'(gnt4), 32'b0010);
    step();
    ready4 = 1'b0; valid4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_ready_in", 32'(rin4), 32'd0);
      chk("stall_grant", 32'(gnt4), 32'b0100);
      step();
      chk("stall_data", 32'(do4), 32'h5A);
      chk("stall_src", 32'(so4), 32'd1);
      chk("stall_valid", 32'(vo4), 32'd1);
    end

    // Flush while full with a competing request
    flush4 = 1'b1; valid4 = 4'b0001;
    #1;
    chk("flush_ready_in", 32'(rin4), 32'd0);
    step();
    chk("flush_valid", 32'(vo4), 32'd0);
    chk("flush_data_kept", 32'(do4), 32'h5A);
    flush4 = 1'b0; valid4 = 4'b1111; ready4 = 1'b1;
    #1;
    chk("flush_prio_kept", 32'(gnt4), 32'b0100);
    step();
    chk("post_flush_src", 32'(so4), 32'd2);
    chk("post_flush_valid", 32'(vo4), 32'd1);

    // Reset while full and stalled
    ready4 = 1'b0; valid4 = 4'b0000;
    step();
    reset = 1'b1; valid4 = 4'b1111;
    #1;
    chk("midrst_ready_in", 32'(rin4), 32'd0);
    step();
    reset = 1'b0;
    chk("midrst_valid", 32'(vo4), 32'd0);
    chk("midrst_data", 32'(do4), 32'h00);
    #1;
    chk("midrst_prio0", 32'(gnt4), 32'b0001);
    valid4 = 4'b1000; ready4 = 1'b1;
    #1;
    chk("midrst_grant3", 32'(gnt4), 32'b1000);
    step();
    chk("midrst_src3", 32'(so4), 32'd3);
    chk("midrst_valid3", 32'(vo4), 32'd1);

    // Mixed flush/ready/valid patterns, checked by the model each cycle
    tbl[0] = {1'b0, 1'b0, 4'b0000}; tbl[1] = {1'b0, 1'b1, 4'b1010};
    tbl[2] = {1'b0, 1'b0, 4'b0110}; tbl[3] = {1'b0, 1'b0, 4'b0110};
    tbl[4] = {1'b1, 1'b1, 4'b1111}; tbl[5] = {1'b0, 1'b1, 4'b0001};
    tbl[6] = {1'b0, 1'b1, 4'b1001}; tbl[7] = {1'b0, 1'b1, 4'b0000};
    tbl[8] = {1'b0, 1'b0, 4'b0100}; tbl[9] = {1'b0, 1'b1, 4'b0100};
    for (int i = 0; i < 10; i++) begin
      flush4 = tbl[i][5]; ready4 = tbl[i][4]; valid4 = tbl[i][3:0];
      d4[i % 4] = 8'hA0 + 8'(i);
      step();
    end
    flush4 = 1'b0; valid4 = 4'b0000;

    // N=3: prio wraps from 2 to 0
    valid3 = 3'b111; ready3 = 1'b1;
    #1;
    chk("n3_first_grant", 32'(gnt3), 32'b001);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("n3_seq_src", 32'(so3), 32'(i % 3));
      chk("n3_seq_data", 32'(do3), 32'h30 + 32'(i % 3));
    end
    valid3 = 3'b000;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
